bus_trace_file_write: RTL and testbench

Bus-operation trace formatter for the split L2 cache model. The cache controller issues bus events (Read, Write, Modify, Invalidate plus the line address). This block queues each event and serialises it as one ASCII text line, for example "R 00001a2f\n", onto a byte stream that feeds a file or UART sink. It replaces the behavioural `bus_display` call with cycle-accurate RTL.

---
 rtl/bus_trace_pkg.sv | 47 ++++
 rtl/bus_trace_fifo.sv | 52 +++++
 rtl/bus_trace_file_write.sv | 157 +++++++++++++++
 tb/tb_bus_trace_file_write.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_trace_pkg.sv
// Shared types and ASCII constants for the bus-operation trace formatter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package bus_trace_pkg;

  typedef enum logic [1:0] {
    OP_R = 2'd0,
    OP_W = 2'd1,
    OP_M = 2'd2,
    OP_I = 2'd3
  } op_code_t;

  // Formatter states; each non-idle state names the byte currently on out_byte.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_SPC,
    ST_HEX,
`ifdef BUS_TRACE_CRLF_EN
    ST_CR,
`endif
    ST_LF
  } fmt_state_t;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_M  = 8'h4D;
  localparam logic [7:0] ASCII_I  = 8'h49;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 0-9 -> '0'-'9', 10-15 -> 'a'-'f' (0x61 - 10 = 0x57).
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

  function automatic logic [7:0] op_to_ascii(input op_code_t op);
    case (op)
      OP_R:    return ASCII_R;
      OP_W:    return ASCII_W;
      OP_M:    return ASCII_M;
      default: return ASCII_I;
    endcase
  endfunction

endpackage

// File: rtl/bus_trace_fifo.sv
// Event queue: DEPTH x WIDTH synchronous FIFO with full/empty flags.
// Latency: a pushed entry is visible on rdata the edge after the push (show-ahead).
// Backpressure: push ignored when full, pop ignored when empty; push+pop together both apply.
module bus_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Read/write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/bus_trace_file_write.sv
// Bus-event trace formatter: queues {op, addr} events, emits "X hhhhhhhh\n" ASCII lines (BUS_TRACE_CRLF_EN adds CR before LF).
// Latency: event accepted at edge N into an idle block is popped at N+1, op char valid from N+2; back-to-back lines have no gap.
// Backpressure: op_ready drops only when tracing and the queue is full; out_valid/out_byte hold until out_ready.
module bus_trace_file_write
  import bus_trace_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trace_en,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [ADDR_W-1:0] op_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              busy
);

  localparam int NDIG  = ADDR_W / 4;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int ENT_W = 2 + ADDR_W;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              handshake;
  logic [ENT_W-1:0]  head;
  op_code_t          head_code;
  logic [ADDR_W-1:0] head_addr;

  fmt_state_t        state;
  op_code_t          hold_code;
  logic [ADDR_W-1:0] hold_addr;
  logic [CNT_W-1:0]  digit_cnt;
  logic [CNT_W-1:0]  nxt_cnt;
  logic [3:0]        nxt_nib;

  // While tracing is off every offer is swallowed so the bus never stalls.
  assign op_ready  = trace_en ? !fifo_full : 1'b1;
  assign push      = op_valid && op_ready && trace_en;
  assign handshake = out_valid && out_ready;
  // Pop when idle, or on the LF handshake so the next line starts without a gap.
  assign pop       = !fifo_empty && ((state == ST_IDLE) || (state == ST_LF && handshake));
  assign busy      = !fifo_empty || (state != ST_IDLE);
  assign head_code = op_code_t'(head[ENT_W-1 -: 2]);
  assign head_addr = head[ADDR_W-1:0];

  bus_trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({op_code, op_addr}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Select the next hex nibble (one position below the current digit).
  always_comb begin
    nxt_cnt = digit_cnt - 1'b1;
    nxt_nib = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (nxt_cnt == CNT_W'(i)) nxt_nib = hold_addr[i*4 +: 4];
    end
  end

  // Line formatter: state names the byte on out_byte, loaded one step ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_code <= OP_R;
      hold_addr <= '0;
      digit_cnt <= '0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            hold_code <= head_code;
            hold_addr <= head_addr;
            state     <= ST_OPC;
          end
        end
        ST_OPC: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_byte  <= op_to_ascii(hold_code);
          end else if (handshake) begin
            out_byte <= ASCII_SP;
            state    <= ST_SPC;
          end
        end
        ST_SPC: begin
          if (handshake) begin
            digit_cnt <= LAST_DIG;
            out_byte  <= nibble_to_ascii(hold_addr[ADDR_W-1 -: 4]);
            state     <= ST_HEX;
          end
        end
        ST_HEX: begin
          if (handshake) begin
            if (digit_cnt == '0) begin
`ifdef BUS_TRACE_CRLF_EN
              out_byte <= ASCII_CR;
              state    <= ST_CR;
`else
              out_byte <= ASCII_LF;
              state    <= ST_LF;
`endif
            end else begin
              digit_cnt <= nxt_cnt;
              out_byte  <= nibble_to_ascii(nxt_nib);
            end
          end
        end
`ifdef BUS_TRACE_CRLF_EN
        ST_CR: begin
          if (handshake) begin
            out_byte <= ASCII_LF;
            state    <= ST_LF;
          end
        end
`endif
        ST_LF: begin
          if (handshake) begin
            if (!fifo_empty) begin
              hold_code <= head_code;
              hold_addr <= head_addr;
              out_byte  <= op_to_ascii(head_code);
              state     <= ST_OPC;
            end else begin
              out_valid <= 1'b0;
              out_byte  <= 8'h00;
              state     <= ST_IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_trace_file_write.sv
// Directed bench for bus_trace_file_write with a byte scoreboard.
// Latency: checks first byte two edges after acceptance and gap-free streaming.
// Backpressure: exercises queue-full, stalled sink and toggled out_ready.
`timescale 1ns/1ps
module tb_bus_trace_file_write;

`ifdef BUS_TRACE_CRLF_EN
  localparam int LINE_LEN = 12;
`else
  localparam int LINE_LEN = 11;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        trace_en;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [31:0] op_addr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        busy;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          hs_count = 0;
  int          last_hs_cyc = 0;
  logic [7:0]  sb [$];
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  bus_trace_file_write #(
    .ADDR_W     (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trace_en  (trace_en),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_addr   (op_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected text line built independently with $sformatf.
  task automatic push_line(input logic [1:0] code, input logic [31:0] addr);
    string opcs;
    string s;
    opcs = "RWMI";
    s = $sformatf("%c %08h", opcs[code], addr);
`ifdef BUS_TRACE_CRLF_EN
    s = {s, "\r"};
`endif
    s = {s, "\n"};
    for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
  endtask

  // Offer one event for one edge; report whether it was accepted.
  task automatic offer(input logic [1:0] code, input logic [31:0] addr, output bit acc);
    @(posedge clk);
    #1;
    op_valid = 1'b1;
    op_code  = code;
    op_addr  = addr;
    @(negedge clk);
    acc = op_ready;
    if (acc && trace_en) push_line(code, addr);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_hs(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (hs_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(hs_count >= target), 32'd1);
  endtask

  // Monitor: compares each handshaken byte to the scoreboard and checks hold-stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_byte", 32'(out_byte), 32'(prev_byte));
      end
      if (out_valid && out_ready) begin
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL spurious_byte: observed %h expected no byte", out_byte);
        end
        if (sb.size() != 0) chk("out_byte", 32'(out_byte), 32'(sb.pop_front()));
        hs_count++;
        last_hs_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_byte;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int c0;
    int base;

    rst = 1'b1;
    trace_en = 1'b1;
    op_valid = 1'b0;
    op_code = 2'd0;
    op_addr = 32'h0;
    out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_byte", 32'(out_byte), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single line and first-byte latency.
    offer(2'd0, 32'h0000_1a2f, acc);
    chk("t1_acc", 32'(acc), 32'd1);
    @(negedge clk);
    chk("t1_valid_n0", 32'(out_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_valid_n1", 32'(out_valid), 32'd0);
    @(negedge clk);
    c0 = cyc;
    chk("t1_valid_n2", 32'(out_valid), 32'd1);
    chk("t1_first_byte", 32'(out_byte), 32'h52);
    wait_drain("t1_drain", 40);
    chk("t1_no_gap", 32'(last_hs_cyc - c0), 32'(LINE_LEN - 1));
    chk("t1_idle", 32'(busy), 32'd0);

    // Queue fill with stalled sink, then gap-free drain.
    @(posedge clk);
    #1 out_ready = 1'b0;
    offer(2'd1, 32'hffff_ffff, acc);
    chk("t2_acc1", 32'(acc), 32'd1);
    offer(2'd2, 32'h0000_0000, acc);
    chk("t2_acc2", 32'(acc), 32'd1);
    offer(2'd3, 32'hdead_beef, acc);
    chk("t2_acc3", 32'(acc), 32'd1);
    offer(2'd0, 32'h1234_5678, acc);
    chk("t2_acc4", 32'(acc), 32'd1);
    @(negedge clk);
    chk("t2_ready_3q", 32'(op_ready), 32'd1);
    offer(2'd1, 32'h0000_abcd, acc);
    chk("t2_acc5", 32'(acc), 32'd1);
    @(negedge clk);
    chk("t2_ready_full", 32'(op_ready), 32'd0);
    offer(2'd2, 32'h5555_aaaa, acc);
    chk("t2_reject6", 32'(acc), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    c0 = cyc;
    base = hs_count;
    wait_drain("t2_drain", 200);
    chk("t2_count", 32'(hs_count - base), 32'(5 * LINE_LEN));
    chk("t2_no_gap", 32'(last_hs_cyc - c0), 32'(5 * LINE_LEN - 1));

    // Tracing disabled: offers swallowed, nothing emitted.
    @(posedge clk);
    #1 trace_en = 1'b0;
    base = hs_count;
    offer(2'd0, 32'h1111_1111, acc);
    chk("t3_acc1", 32'(acc), 32'd1);
    offer(2'd1, 32'h2222_2222, acc);
    chk("t3_acc2", 32'(acc), 32'd1);
    offer(2'd2, 32'h3333_3333, acc);
    chk("t3_acc3", 32'(acc), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("t3_busy", 32'(busy), 32'd0);
    end
    chk("t3_no_bytes", 32'(hs_count - base), 32'd0);

    // Dropping trace_en mid-line still completes the line.
    @(posedge clk);
    #1 trace_en = 1'b1;
    base = hs_count;
    offer(2'd2, 32'h0000_0010, acc);
    wait_hs("t3_mid_wait", base + 3, 20);
    @(posedge clk);
    #1 trace_en = 1'b0;
    wait_drain("t3_mid_drain", 40);
    chk("t3_mid_count", 32'(hs_count - base), 32'(LINE_LEN));
    chk("t3_mid_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1 trace_en = 1'b1;

    // out_ready toggled every other cycle.
    @(posedge clk);
    #1 out_ready = 1'b0;
    base = hs_count;
    offer(2'd3, 32'hdead_beef, acc);
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1 out_ready = ~out_ready;
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain("t4_drain", 10);
    chk("t4_count", 32'(hs_count - base), 32'(LINE_LEN));

    // Reset mid-line truncates; next line is fresh.
    base = hs_count;
    offer(2'd0, 32'hcafe_0001, acc);
    wait_hs("t5_wait", base + 4, 20);
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    base = hs_count;
    offer(2'd0, 32'h0bad_f00d, acc);
    chk("t5_acc", 32'(acc), 32'd1);
    wait_drain("t5_drain", 40);
    chk("t5_count", 32'(hs_count - base), 32'(LINE_LEN));

    // Final idle state.
    repeat (2) @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
